// File: rtl/need_sched_pkg.sv
// Shared constants, mode encodings and arbitration helpers for the need-decay scheduler.
package need_sched_pkg;

    localparam int unsigned STAT_W     = 4;
    localparam int unsigned NUM_STATS  = 3;
    localparam int unsigned ACCEL_STEP = 4;

    localparam int unsigned T_HAMBRE_DEF  = 15;
    localparam int unsigned T_ENERGIA_DEF = 20;
    localparam int unsigned T_DIVER_DEF   = 10;
    localparam int unsigned INC_DEF       = 3;
    localparam int unsigned CRIT_DEF      = 3;

    localparam logic [1:0] IDX_HAMBRE  = 2'd0;
    localparam logic [1:0] IDX_ENERGIA = 2'd1;
    localparam logic [1:0] IDX_DIVER   = 2'd2;

    typedef enum logic [1:0] {
        MODO_RUN   = 2'b00,
        MODO_SLEEP = 2'b01,
        MODO_DEAD  = 2'b10
    } modo_t;

    function automatic int unsigned tmax3(input int unsigned a, input int unsigned b,
                                          input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int unsigned TMR_W = $clog2(tmax3(T_HAMBRE_DEF, T_ENERGIA_DEF, T_DIVER_DEF));

    // Next round-robin start after granting stat g.
    function automatic logic [1:0] rr_next(input logic [1:0] g);
        return (g == 2'd2) ? 2'd0 : 2'(g + 2'd1);
    endfunction

    // First pending stat found scanning upward (mod 3) from start.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] start);
        logic [1:0]  pick;
        logic        found;
        int unsigned c;
        pick  = start;
        found = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            c = (32'(start) + k) % 3;
            if (!found && req[c]) begin
                pick  = 2'(c);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/need_decay_timer.sv
// Per-stat decay period counter with a one-bit pending-event flag.
module need_decay_timer #(
    parameter int unsigned T  = 10,
    parameter int unsigned TW = 5
) (
    input  logic          clk_1Hz,
    input  logic          reset,
    input  logic          run,
    input  logic          clear,
    input  logic [TW-1:0] step,
    output logic          pend
);

    localparam int unsigned SW = TW + 1;

    logic [TW-1:0] cnt;
    logic [SW-1:0] cnt_sum_c;
    logic          event_c;

    // Wide sum so the period comparison cannot wrap.
    always_comb begin
        cnt_sum_c = {1'b0, cnt} + {1'b0, step};
        event_c   = run && (cnt_sum_c >= SW'(T));
    end

    // Counter advances only while running; a new event beats a same-edge clear.
    always_ff @(posedge clk_1Hz) begin
        if (reset) begin
            cnt  <= '0;
            pend <= 1'b0;
        end else if (run) begin
            if (event_c) begin
                cnt  <= '0;
                pend <= 1'b1;
            end else begin
                cnt <= cnt_sum_c[TW-1:0];
                if (clear) begin
                    pend <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/need_decay_scheduler.sv
// Pet need scheduler: three decay timers, one saturating update unit, RUN/SLEEP/DEAD FSM.
// Optional NEED_SCHED_ACCEL_EN adds input acelerar, which makes every timer step by 4.
module need_decay_scheduler
    import need_sched_pkg::*;
#(
    parameter int unsigned W         = STAT_W,
    parameter int unsigned T_HAMBRE  = T_HAMBRE_DEF,
    parameter int unsigned T_ENERGIA = T_ENERGIA_DEF,
    parameter int unsigned T_DIVER   = T_DIVER_DEF,
    parameter int unsigned INC       = INC_DEF,
    parameter int unsigned CRIT      = CRIT_DEF
) (
    input  logic         clk_1Hz,
    input  logic         reset,
    input  logic         req_comer,
    input  logic         req_jugar,
    input  logic         req_dormir,
`ifdef NEED_SCHED_ACCEL_EN
    input  logic         acelerar,
`endif
    output logic [W-1:0] hambre,
    output logic [W-1:0] energia,
    output logic [W-1:0] diversion,
    output logic [1:0]   modo,
    output logic [2:0]   critico,
    output logic         muerto,
    output logic         upd_valid,
    output logic [1:0]   upd_idx
);

    localparam int unsigned TW = tmax3(TMR_W,
        $clog2(tmax3(T_HAMBRE, T_ENERGIA, T_DIVER) + ACCEL_STEP), 1);
    localparam logic [W-1:0] STAT_MAX = {W{1'b1}};

    modo_t                         modo_q, modo_d;
    logic [NUM_STATS-1:0][W-1:0]   stat_q, stat_d;
    logic [1:0]                    rr_q;
    logic [2:0]                    pend;
    logic [2:0]                    clr_c;
    logic                          run_c;
    logic [TW-1:0]                 step_c;
    logic                          upd_c, grant_c, add_c, dead_c;
    logic [1:0]                    sel_c;
    logic [W-1:0]                  amt_c, cur_c, new_c;
    logic [W:0]                    sum_c;

    // Timers run in RUN and SLEEP; DEAD freezes counters and pend flags.
    always_comb begin
        run_c = (modo_q != MODO_DEAD);
`ifdef NEED_SCHED_ACCEL_EN
        step_c = acelerar ? TW'(ACCEL_STEP) : TW'(1);
`else
        step_c = TW'(1);
`endif
    end

    need_decay_timer #(.T(T_HAMBRE), .TW(TW)) u_tmr_hambre (
        .clk_1Hz (clk_1Hz),
        .reset   (reset),
        .run     (run_c),
        .clear   (clr_c[IDX_HAMBRE]),
        .step    (step_c),
        .pend    (pend[IDX_HAMBRE])
    );

    need_decay_timer #(.T(T_ENERGIA), .TW(TW)) u_tmr_energia (
        .clk_1Hz (clk_1Hz),
        .reset   (reset),
        .run     (run_c),
        .clear   (clr_c[IDX_ENERGIA]),
        .step    (step_c),
        .pend    (pend[IDX_ENERGIA])
    );

    need_decay_timer #(.T(T_DIVER), .TW(TW)) u_tmr_diver (
        .clk_1Hz (clk_1Hz),
        .reset   (reset),
        .run     (run_c),
        .clear   (clr_c[IDX_DIVER]),
        .step    (step_c),
        .pend    (pend[IDX_DIVER])
    );

    // Arbitration: feed, then play (RUN only), then round-robin over pending decay events.
    always_comb begin
        upd_c   = 1'b0;
        grant_c = 1'b0;
        add_c   = 1'b0;
        sel_c   = IDX_HAMBRE;
        amt_c   = '0;
        clr_c   = '0;
        if (modo_q != MODO_DEAD) begin
            if (req_comer) begin
                upd_c = 1'b1;
                sel_c = IDX_HAMBRE;
                add_c = 1'b1;
                amt_c = W'(INC);
            end else if (req_jugar && (modo_q == MODO_RUN)) begin
                upd_c = 1'b1;
                sel_c = IDX_DIVER;
                add_c = 1'b1;
                amt_c = W'(INC);
            end else if (|pend) begin
                upd_c   = 1'b1;
                grant_c = 1'b1;
                sel_c   = rr_pick(pend, rr_q);
                amt_c   = W'(1);
                add_c   = (modo_q == MODO_SLEEP) && (sel_c == IDX_ENERGIA);
                for (int unsigned i = 0; i < NUM_STATS; i++) begin
                    if (sel_c == 2'(i)) begin
                        clr_c[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Saturating add/subtract on the selected stat.
    always_comb begin
        cur_c = '0;
        for (int unsigned i = 0; i < NUM_STATS; i++) begin
            if (sel_c == 2'(i)) begin
                cur_c = stat_q[i];
            end
        end
        sum_c = {1'b0, cur_c} + {1'b0, amt_c};
        if (add_c) begin
            new_c = sum_c[W] ? STAT_MAX : sum_c[W-1:0];
        end else begin
            new_c = (cur_c < amt_c) ? '0 : (cur_c - amt_c);
        end
        stat_d = stat_q;
        for (int unsigned i = 0; i < NUM_STATS; i++) begin
            if (upd_c && (sel_c == 2'(i))) begin
                stat_d[i] = new_c;
            end
        end
    end

    // Stat registers, round-robin pointer and update report.
    always_ff @(posedge clk_1Hz) begin
        if (reset) begin
            stat_q    <= {NUM_STATS{STAT_MAX}};
            rr_q      <= 2'd0;
            upd_valid <= 1'b0;
            upd_idx   <= 2'd0;
        end else begin
            stat_q    <= stat_d;
            upd_valid <= upd_c;
            if (upd_c) begin
                upd_idx <= sel_c;
            end
            if (grant_c) begin
                rr_q <= rr_next(sel_c);
            end
        end
    end

    // Mode state register.
    always_ff @(posedge clk_1Hz) begin
        if (reset) begin
            modo_q <= MODO_RUN;
        end else begin
            modo_q <= modo_d;
        end
    end

    // Mode transitions; starvation of both hambre and diversion wins over sleep toggling.
    always_comb begin
        modo_d = modo_q;
        dead_c = (stat_q[IDX_HAMBRE] == '0) && (stat_q[IDX_DIVER] == '0);
        case (modo_q)
            MODO_RUN: begin
                if (dead_c) begin
                    modo_d = MODO_DEAD;
                end else if (req_dormir) begin
                    modo_d = MODO_SLEEP;
                end
            end
            MODO_SLEEP: begin
                if (dead_c) begin
                    modo_d = MODO_DEAD;
                end else if (req_dormir || (stat_q[IDX_ENERGIA] == STAT_MAX)) begin
                    modo_d = MODO_RUN;
                end
            end
            MODO_DEAD: begin
                modo_d = MODO_DEAD;
            end
            default: begin
                modo_d = MODO_RUN;
            end
        endcase
    end

    // Outputs derived from registered state.
    always_comb begin
        hambre    = stat_q[IDX_HAMBRE];
        energia   = stat_q[IDX_ENERGIA];
        diversion = stat_q[IDX_DIVER];
        modo      = modo_q;
        muerto    = (modo_q == MODO_DEAD);
        for (int unsigned i = 0; i < NUM_STATS; i++) begin
            critico[i] = (stat_q[i] <= W'(CRIT));
        end
    end

endmodule
